alu_issue_ctrl: RTL and testbench

//  Initiator side of the 3-bit ALU func interface: decodes a MIPS-style op into an ALU func code.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU func codes, MIPS opcode/funct constants and issue FSM states
package alu_pkg;

  localparam logic [2:0] FUNC_ADD  = 3'd0;
  localparam logic [2:0] FUNC_SUB  = 3'd1;
  localparam logic [2:0] FUNC_AND  = 3'd2;
  localparam logic [2:0] FUNC_OR   = 3'd3;
  localparam logic [2:0] FUNC_NOR  = 3'd4;
  localparam logic [2:0] FUNC_IDLE = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode/funct/imm decode to ALU func and b operand
// Unknown opcodes or R-type functs yield FUNC_IDLE so the ALU produces zero.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [5:0]      i_opcode,
  input  logic [5:0]      i_funct,
  input  logic [SIZE-1:0] i_rt_val,
  input  logic [15:0]     i_imm,
  output logic [2:0]      o_func,
  output logic [SIZE-1:0] o_b,
  output logic            o_is_beq,
  output logic            o_illegal
);

  logic [SIZE-1:0] w_imm_sext;
  logic [SIZE-1:0] w_imm_zext;

  assign w_imm_sext = {{(SIZE-16){i_imm[15]}}, i_imm};
  assign w_imm_zext = {{(SIZE-16){1'b0}}, i_imm};

  always_comb begin
    o_func    = FUNC_IDLE;
    o_b       = i_rt_val;
    o_is_beq  = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_func = FUNC_ADD;
          FN_SUB:  o_func = FUNC_SUB;
          FN_AND:  o_func = FUNC_AND;
          FN_OR:   o_func = FUNC_OR;
          FN_NOR:  o_func = FUNC_NOR;
          default: o_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        o_func = FUNC_ADD;
        o_b    = w_imm_sext;
      end
      OP_ANDI: begin
        o_func = FUNC_AND;
        o_b    = w_imm_zext;
      end
      OP_ORI: begin
        o_func = FUNC_OR;
        o_b    = w_imm_zext;
      end
      OP_BEQ: begin
        o_func   = FUNC_SUB;
        o_is_beq = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded op to an external ALU and buffers its response
// Three-state walk IDLE -> EXEC -> RESP; operands stay frozen between accepts.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_opcode,
  input  logic [5:0]      req_funct,
  input  logic [SIZE-1:0] req_rs_val,
  input  logic [SIZE-1:0] req_rt_val,
  input  logic [15:0]     req_imm,
  output logic [SIZE-1:0] alu_a,
  output logic [SIZE-1:0] alu_b,
  output logic [2:0]      alu_func,
  input  logic [SIZE-1:0] alu_out,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_branch_taken,
  output logic            rsp_illegal
);

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_capture;

  logic [2:0]      w_dec_func;
  logic [SIZE-1:0] w_dec_b;
  logic            w_dec_is_beq;
  logic            w_dec_illegal;

  logic [SIZE-1:0] r_alu_a;
  logic [SIZE-1:0] r_alu_b;
  logic [2:0]      r_alu_func;
  logic            r_is_beq;
  logic            r_illegal;

  logic [SIZE-1:0] r_rsp_result;
  logic            r_rsp_zero;
  logic            r_rsp_taken;
  logic            r_rsp_illegal;

  alu_op_decode #(.SIZE(SIZE)) u_decode (
    .i_opcode  (req_opcode),
    .i_funct   (req_funct),
    .i_rt_val  (req_rt_val),
    .i_imm     (req_imm),
    .o_func    (w_dec_func),
    .o_b       (w_dec_b),
    .o_is_beq  (w_dec_is_beq),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture = 1'b1;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_func <= FUNC_IDLE;
      r_is_beq   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_alu_a    <= req_rs_val;
      r_alu_b    <= w_dec_b;
      r_alu_func <= w_dec_func;
      r_is_beq   <= w_dec_is_beq;
      r_illegal  <= w_dec_illegal;
    end
  end

  // Illegal ops never count as taken branches even though the ALU reports zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_taken   <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result  <= alu_out;
      r_rsp_zero    <= alu_zero;
      r_rsp_taken   <= r_is_beq & alu_zero & ~r_illegal;
      r_rsp_illegal <= r_illegal;
    end
  end

  assign req_ready        = (r_state == ST_IDLE);
  assign rsp_valid        = (r_state == ST_RESP);
  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_func         = r_alu_func;
  assign rsp_result       = r_rsp_result;
  assign rsp_zero         = r_rsp_zero;
  assign rsp_branch_taken = r_rsp_taken;
  assign rsp_illegal      = r_rsp_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [2:0]  func;
    logic [31:0] res;
    logic        z;
    logic        t;
    logic        il;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = '0;
  logic [5:0]  req_funct = '0;
  logic [31:0] req_rs_val = '0;
  logic [31:0] req_rt_val = '0;
  logic [15:0] req_imm = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_func;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_branch_taken;
  logic        rsp_illegal;

  vec_t tbl [12];
  vec_t sb_q [$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_func)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a | alu_b;
      3'd4:    alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  alu_issue_ctrl #(.SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_funct        (req_funct),
    .req_rs_val       (req_rs_val),
    .req_rt_val       (req_rt_val),
    .req_imm          (req_imm),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_func         (alu_func),
    .alu_out          (alu_out),
    .alu_zero         (alu_zero),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_zero         (rsp_zero),
    .rsp_branch_taken (rsp_branch_taken),
    .rsp_illegal      (rsp_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
        check("rsp_taken", {31'd0, rsp_branch_taken}, {31'd0, e.t});
        check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.il});
      end
    end
  end

  task automatic issue(input int idx);
    int n;
    @(negedge clk);
    req_opcode = tbl[idx].op;
    req_funct  = tbl[idx].fn;
    req_rs_val = tbl[idx].rs;
    req_rt_val = tbl[idx].rt;
    req_imm    = tbl[idx].imm;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back(tbl[idx]);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    check("alu_func_n1", {29'd0, alu_func}, {29'd0, tbl[idx].func});
    check("alu_a_n1", alu_a, tbl[idx].rs);
    check("rsp_valid_n1", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_exec", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rsp_valid_n2", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{6'h00, 6'h20, 32'd5,          32'd7,      16'h0000, 3'd0, 32'd12,         1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'h04, 6'h00, 32'h1234,       32'h1234,   16'h0000, 3'd1, 32'd0,          1'b1, 1'b1, 1'b0};
    tbl[2]  = '{6'h04, 6'h00, 32'h1234,       32'h1235,   16'h0000, 3'd1, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6'h08, 6'h00, 32'd10,         32'd0,      16'hFFFF, 3'd0, 32'd9,          1'b0, 1'b0, 1'b0};
    tbl[4]  = '{6'h0C, 6'h00, 32'hFFFF_FFFF,  32'd0,      16'h8001, 3'd2, 32'h0000_8001,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'h00, 6'h27, 32'd0,          32'd0,      16'h0000, 3'd4, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{6'h3F, 6'h20, 32'h55,         32'h55,     16'h1234, 3'd7, 32'd0,          1'b1, 1'b0, 1'b1};
    tbl[7]  = '{6'h0D, 6'h00, 32'h00F0,       32'd0,      16'h0F0F, 3'd3, 32'h0000_0FFF,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{6'h00, 6'h22, 32'd3,          32'd3,      16'h0000, 3'd1, 32'd0,          1'b1, 1'b0, 1'b0};
    tbl[9]  = '{6'h00, 6'h24, 32'hF0F0,       32'hFF00,   16'h0000, 3'd2, 32'h0000_F000,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{6'h00, 6'h25, 32'd1,          32'd2,      16'h0000, 3'd3, 32'd3,          1'b0, 1'b0, 1'b0};
    tbl[11] = '{6'h00, 6'h21, 32'd8,          32'd9,      16'h0000, 3'd7, 32'd0,          1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", {29'd0, rsp_zero, rsp_branch_taken, rsp_illegal}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_func", {29'd0, alu_func}, 32'd7);

    // Back-to-back stream with the consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(i);
      if (i > 0) check("b2b_gap", acc_cyc - last_acc, 32'd3);
      last_acc = acc_cyc;
    end
    wait_drain();

    // Consumer stalls: response held and further requests refused.
    rsp_ready = 1'b0;
    issue(0);
    req_opcode = tbl[1].op;
    req_rs_val = tbl[1].rs;
    req_rt_val = tbl[1].rt;
    req_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_result", rsp_result, 32'd12);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("hold_alu_a", alu_a, 32'd5);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset while a response is pending discards it.
    rsp_ready = 1'b0;
    issue(3);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    sb_q.delete();
    check("rstresp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstresp_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstresp_alu_func", {29'd0, alu_func}, 32'd7);
    check("rstresp_rsp_result", rsp_result, 32'd0);

    issue(5);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
